// File: rtl/inverse_gamma_stream_if.sv
// Valid/ready pixel stream bundle used on both sides of the inverse-gamma unit.
// The master drives data and markers; the slave returns ready.
interface inverse_gamma_stream_if #(
  parameter int CHANNELS = 3
);
  logic [8*CHANNELS-1:0] tdata;
  logic                  tvalid;
  logic                  tready;
  logic                  tuser;
  logic                  tlast;

  modport master (output tdata, output tvalid, output tuser, output tlast, input tready);
  modport slave  (input tdata, input tvalid, input tuser, input tlast, output tready);
endinterface

// File: rtl/inverse_gamma_stream.sv
// Streaming inverse-gamma (gamma 2.0) linearisation, three register stages.
// S1 holds the squared channels, S2 holds the rounded quotient, S3 drives the
// output stream. One global enable advances or freezes the whole pipe, so a
// stall holds up to three beats. tuser, tlast and bypass travel with each beat.
module inverse_gamma_stream #(
  parameter int CHANNELS = 3
) (
  input  logic                   clk,
  input  logic                   rst,
  inverse_gamma_stream_if.slave  s,
  inverse_gamma_stream_if.master m,
  input  logic                   bypass,
  output logic [23:0]            pix_count
);

  localparam int W = 8 * CHANNELS;

  logic          en;

  logic          v1_q, v2_q, v3_q;
  logic          user1_q, user2_q, user3_q;
  logic          last1_q, last2_q, last3_q;
  logic          byp1_q, byp2_q;
  logic [W-1:0]  raw1_q, raw2_q;
  logic [15:0]   prod_q [CHANNELS];
  logic [15:0]   prod_d [CHANNELS];
  logic [7:0]    quot_q [CHANNELS];
  logic [7:0]    quot_d [CHANNELS];
  logic [W-1:0]  data3_q, data3_d;
  logic [23:0]   cnt_q, cnt_d;

  assign en       = !v3_q || m.tready;
  assign s.tready = en && !rst;

  assign m.tvalid = v3_q;
  assign m.tdata  = data3_q;
  assign m.tuser  = user3_q;
  assign m.tlast  = last3_q;
  assign pix_count = cnt_q;

  // Per-channel arithmetic feeding each stage: square, round-divide by 255, bypass select
  always_comb begin
    logic [15:0] q;
    q       = '0;
    data3_d = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      prod_d[c] = 16'(s.tdata[8*c +: 8]) * 16'(s.tdata[8*c +: 8]);
      q         = prod_q[c] + 16'd128;
      quot_d[c] = 8'((q + (q >> 8)) >> 8);
      data3_d[8*c +: 8] = byp2_q ? raw2_q[8*c +: 8] : quot_q[c];
    end
  end

  // Pipeline registers; all stages load together when enabled so bubbles move with the data
  always_ff @(posedge clk) begin
    if (rst) begin
      v1_q    <= 1'b0;
      v2_q    <= 1'b0;
      v3_q    <= 1'b0;
      user1_q <= 1'b0;
      user2_q <= 1'b0;
      user3_q <= 1'b0;
      last1_q <= 1'b0;
      last2_q <= 1'b0;
      last3_q <= 1'b0;
      byp1_q  <= 1'b0;
      byp2_q  <= 1'b0;
      raw1_q  <= '0;
      raw2_q  <= '0;
      data3_q <= '0;
      for (int c = 0; c < CHANNELS; c++) begin
        prod_q[c] <= '0;
        quot_q[c] <= '0;
      end
    end else if (en) begin
      v1_q    <= s.tvalid && s.tready;
      user1_q <= s.tuser;
      last1_q <= s.tlast;
      byp1_q  <= bypass;
      raw1_q  <= s.tdata;

      v2_q    <= v1_q;
      user2_q <= user1_q;
      last2_q <= last1_q;
      byp2_q  <= byp1_q;
      raw2_q  <= raw1_q;

      v3_q    <= v2_q;
      user3_q <= user2_q;
      last3_q <= last2_q;
      data3_q <= data3_d;

      for (int c = 0; c < CHANNELS; c++) begin
        prod_q[c] <= prod_d[c];
        quot_q[c] <= quot_d[c];
      end
    end
  end

  // Next pixel count: restart at 1 on a start-of-frame beat, otherwise count up and saturate
  always_comb begin
    cnt_d = cnt_q;
    if (v3_q && m.tready) begin
      if (user3_q) begin
        cnt_d = 24'd1;
      end else if (cnt_q != 24'hFFFFFF) begin
        cnt_d = cnt_q + 24'd1;
      end
    end
  end

  // Pixel count register
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: tb/tb_inverse_gamma_stream.sv
// Testbench for inverse_gamma_stream: scoreboard of expected beats filled on
// input handshakes and drained on output handshakes, plus a pixel-count model.
module tb_inverse_gamma_stream;

  logic        clk;
  logic        rst;
  logic        bypassIn;
  logic [23:0] pixCount;

  inverse_gamma_stream_if #(.CHANNELS(3)) sIf ();
  inverse_gamma_stream_if #(.CHANNELS(3)) mIf ();

  inverse_gamma_stream #(.CHANNELS(3)) dut (
    .clk       (clk),
    .rst       (rst),
    .s         (sIf.slave),
    .m         (mIf.master),
    .bypass    (bypassIn),
    .pix_count (pixCount)
  );

  int          checkCount = 0;
  int          errorCount = 0;
  logic [25:0] sb[$];
  logic [23:0] lastOut = '0;
  logic [23:0] modelCnt = '0;
  logic        prevRst = 1'b0;
  logic        stalled = 1'b0;
  logic        bpRandom = 1'b0;

  // Free-running clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Hard time limit so the run always ends
  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checkCount++;
    if (actual !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, actual, expected);
    end
  endtask

  // Reference: round(x*x/255) per channel, or raw data when bypassed
  function automatic logic [23:0] gammaModel(input logic [23:0] d, input logic byp);
    logic [23:0] res;
    int x;
    res = '0;
    for (int c = 0; c < 3; c++) begin
      x = int'(d[8*c +: 8]);
      res[8*c +: 8] = byp ? d[8*c +: 8] : 8'((2 * x * x + 255) / 510);
    end
    return res;
  endfunction

  // Random output backpressure when enabled
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (bpRandom) mIf.tready = ($urandom_range(0, 1) == 1);
    end
  end

  // Monitor on the falling edge: inputs and outputs are stable here
  always @(negedge clk) begin
    if (rst) begin
      checkOutput("rstReady", 32'(sIf.tready), 32'd0);
      sb.delete();
      modelCnt = '0;
      prevRst  = 1'b1;
      stalled  = 1'b0;
    end else begin
      if (prevRst) begin
        checkOutput("postRstValid", 32'(mIf.tvalid), 32'd0);
        checkOutput("postRstData", 32'(mIf.tdata), 32'd0);
        checkOutput("postRstReady", 32'(sIf.tready), 32'd1);
      end
      prevRst = 1'b0;
      checkOutput("pixCount", 32'(pixCount), 32'(modelCnt));
      if (stalled) checkOutput("stallValid", 32'(mIf.tvalid), 32'd1);
      if (mIf.tvalid) begin
        if (sb.size() == 0) begin
          checkOutput("spuriousValid", 32'(mIf.tvalid), 32'd0);
        end else begin
          checkOutput("outBeat", 32'({mIf.tuser, mIf.tlast, mIf.tdata}), 32'(sb[0]));
          if (mIf.tready) begin
            void'(sb.pop_front());
            lastOut = mIf.tdata;
            if (mIf.tuser) modelCnt = 24'd1;
            else if (modelCnt != 24'hFFFFFF) modelCnt = modelCnt + 24'd1;
          end
        end
      end
      stalled = mIf.tvalid && !mIf.tready;
      if (sIf.tvalid && sIf.tready)
        sb.push_back({sIf.tuser, sIf.tlast, gammaModel(sIf.tdata, bypassIn)});
    end
  end

  // Present one beat and hold it until accepted; returns just after the accepting edge
  task automatic applyStimulus(input logic [23:0] d, input logic u, input logic l, input logic b);
    int guard;
    sIf.tdata  = d;
    sIf.tuser  = u;
    sIf.tlast  = l;
    bypassIn   = b;
    sIf.tvalid = 1'b1;
    guard = 0;
    @(negedge clk);
    while (!sIf.tready && guard < 1000) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 1000) checkOutput("acceptTimeout", 32'(sIf.tready), 32'd1);
    @(posedge clk);
    #1;
    sIf.tvalid = 1'b0;
  endtask

  // Wait until every expected beat has come out
  task automatic waitDrain();
    int guard;
    guard = 0;
    while ((sb.size() != 0 || mIf.tvalid) && guard < 200) begin
      @(posedge clk);
      #1;
      guard++;
    end
    if (guard >= 200) checkOutput("drainTimeout", 32'(sb.size()), 32'd0);
  endtask

  initial begin
    rst        = 1'b1;
    sIf.tvalid = 1'b0;
    sIf.tdata  = '0;
    sIf.tuser  = 1'b0;
    sIf.tlast  = 1'b0;
    bypassIn   = 1'b0;
    mIf.tready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("resetValid", 32'(mIf.tvalid), 32'd0);
    checkOutput("resetCount", 32'(pixCount), 32'd0);
    rst        = 1'b0;
    mIf.tready = 1'b1;

    // Full-range sweep on all channels
    for (int x = 0; x < 256; x++) applyStimulus({3{8'(x)}}, 1'b0, 1'b0, 1'b0);
    waitDrain();

    // Directed values with fixed expectations
    applyStimulus(24'h80C810, 1'b0, 1'b0, 1'b1);
    waitDrain();
    checkOutput("bypassBeat", 32'(lastOut), 32'h0080C810);
    applyStimulus(24'h80C810, 1'b0, 1'b0, 1'b0);
    waitDrain();
    checkOutput("gammaBeat", 32'(lastOut), 32'h00409D01);
    applyStimulus(24'hFF0100, 1'b0, 1'b0, 1'b0);
    waitDrain();
    checkOutput("edgeBeat", 32'(lastOut), 32'h00FF0000);

    // Random data, markers and bypass under random backpressure
    bpRandom = 1'b1;
    for (int i = 0; i < 1000; i++) begin
      applyStimulus(24'($urandom), $urandom_range(0, 15) == 0, $urandom_range(0, 3) == 0,
                    $urandom_range(0, 1) == 1);
      if ($urandom_range(0, 3) == 0) begin
        @(posedge clk);
        #1;
      end
    end
    bpRandom = 1'b0;
    @(posedge clk);
    #1;
    mIf.tready = 1'b1;
    waitDrain();

    // One frame: 4 lines of 5 beats, then a new start-of-frame beat
    for (int i = 0; i < 20; i++)
      applyStimulus(24'($urandom), i == 0, (i % 5) == 4, 1'b0);
    waitDrain();
    checkOutput("frameCount", 32'(pixCount), 32'd20);
    applyStimulus(24'h123456, 1'b1, 1'b0, 1'b0);
    waitDrain();
    checkOutput("newFrameCount", 32'(pixCount), 32'd1);

    // Reset with a full, stalled pipe
    mIf.tready = 1'b0;
    for (int i = 0; i < 3; i++) applyStimulus(24'hA0A0A0 + 24'(i), 1'b0, 1'b0, 1'b0);
    checkOutput("pipeFullStall", 32'(sIf.tready), 32'd0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst        = 1'b0;
    mIf.tready = 1'b1;
    repeat (6) begin
      @(posedge clk);
      #1;
    end
    checkOutput("noStaleBeat", 32'(mIf.tvalid), 32'd0);
    checkOutput("postRstCount", 32'(pixCount), 32'd0);
    applyStimulus(24'h101010, 1'b1, 1'b1, 1'b0);
    waitDrain();
    checkOutput("recoverBeat", 32'(lastOut), 32'h00010101);
    checkOutput("sbEmpty", 32'(sb.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

endmodule
